// File: rtl/matrix_stream_out_pkg.sv
// Shared types and sizing for the matrix stream egress block and its index counter.
package matrix_stream_out_pkg;

    localparam int unsigned WIDTH_BIT = 2;
    localparam int unsigned WIDTH  = 1 << WIDTH_BIT;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    typedef logic [WIDTH_BIT-1:0]                          idx_t;
    typedef logic [0:1][WIDTH_BIT-1:0]                     size_t;
    typedef logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]       mat_t;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) walker over an active rows x cols window; wraps to (0,0) after the last element.
module matrix_index_counter
    import matrix_stream_out_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [WIDTH_BIT-1:0] rows_m1,
    input  logic [WIDTH_BIT-1:0] cols_m1,
    output logic [WIDTH_BIT-1:0] row,
    output logic [WIDTH_BIT-1:0] col,
    output logic                 at_last
);

    idx_t row_q, row_d;
    idx_t col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == cols_m1) begin
                col_d = '0;
                row_d = (row_q == rows_m1) ? '0 : idx_t'(row_q + 1'b1);
            end else begin
                col_d = idx_t'(col_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign at_last = (row_q == rows_m1) && (col_q == cols_m1);

endmodule

// File: rtl/matrix_stream_out.sv
// Captures a WIDTH x WIDTH matrix on start and streams its active sub-matrix row-major,
// one element per valid/ready beat, followed by a one-cycle done pulse.
module matrix_stream_out
    import matrix_stream_out_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  size_t                size,
    input  mat_t                 mat,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [WIDTH_BIT-1:0] out_row,
    output logic [WIDTH_BIT-1:0] out_col,
    output logic                 out_last,
    output logic                 done
);

    state_e state_q, state_d;
    mat_t   buf_q, buf_d;
    size_t  size_q, size_d;
    logic   valid_q, valid_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic   cnt_clear, cnt_advance, at_last;
    idx_t   row, col;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        size_d      = size_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    buf_d     = mat;
                    size_d    = size;
                    cnt_clear = 1'b1;
                    state_d   = StSend;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StSend: begin
                if (valid_q && out_ready) begin
                    cnt_advance = 1'b1;
                    if (at_last) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            buf_q   <= '0;
            size_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            size_q  <= size_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    matrix_index_counter u_index (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .rows_m1 (size_q[0]),
        .cols_m1 (size_q[1]),
        .row     (row),
        .col     (col),
        .at_last (at_last)
    );

    // Index registers only move on a transfer, so data/row/col hold under backpressure.
    assign out_data  = buf_q[row][col];
    assign out_row   = row;
    assign out_col   = col;
    assign out_last  = at_last & valid_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
